// File: rtl/cla_issue_arbiter.sv
// cla_issue_arbiter: round-robin issue controller for one shared pipelined
// 16-bit carry-look-ahead adder. It grants one add per cycle, tracks every
// issued op through a tag pipe matched to the adder latency, and steers each
// result back to its requester. A pause/drain FSM quiesces the adder.
//
// Build option: define CLA_ARB_ZERO_IDLE_EN to drive zero operands on
// non-grant cycles. Otherwise the operands hold the last issued values.
module cla_issue_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 5,
  parameter int TW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      gnt,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  input  logic [16:0]          add_sum,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [16:0]          rsp_sum,
  input  logic                 pause,
  output logic                 idle,
  output logic [3:0]           inflight
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_PAUSED} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   last_reg;
  logic [TW-1:0]   pick_idx;
  logic [TW-1:0]   cand_idx;
  logic            pick_any;
  logic            issue;
  logic [15:0]     sel_a, sel_b;
  logic            vld_reg [LAT];
  logic [TW-1:0]   tag_reg [LAT];
  logic [3:0]      inflight_reg, inflight_next;

  // Round-robin search: walk from last+1 upward; the closest requester wins.
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    cand_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_idx = TW'((int'(last_reg) + k) % NREQ);
      if (req[cand_idx]) begin
        pick_idx = cand_idx;
        pick_any = 1'b1;
      end
    end
  end

  // Issue only while running and not being asked to pause; never during reset.
  assign issue = reset && (state_reg == ST_RUN) && !pause && pick_any;
  assign sel_a = req_a[int'(pick_idx)*16 +: 16];
  assign sel_b = req_b[int'(pick_idx)*16 +: 16];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_decode
      assign gnt[gi]       = issue && (pick_idx == TW'(gi));
      assign rsp_valid[gi] = vld_reg[LAT-1] && (tag_reg[LAT-1] == TW'(gi));
    end
  endgenerate

`ifdef CLA_ARB_ZERO_IDLE_EN
  assign add_a = issue ? sel_a : 16'h0000;
  assign add_b = issue ? sel_b : 16'h0000;
`else
  logic [15:0] hold_a_reg, hold_b_reg;

  // Remember the last issued operands so the adder inputs stay quiet between grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_a_reg <= 16'h0000;
      hold_b_reg <= 16'h0000;
    end else if (issue) begin
      hold_a_reg <= sel_a;
      hold_b_reg <= sel_b;
    end
  end

  assign add_a = issue ? sel_a : hold_a_reg;
  assign add_b = issue ? sel_b : hold_b_reg;
`endif

  // Tag pipe mirrors the adder pipeline: {valid, requester} per stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < LAT; s++) begin
        vld_reg[s] <= 1'b0;
        tag_reg[s] <= '0;
      end
    end else begin
      vld_reg[0] <= issue;
      tag_reg[0] <= pick_idx;
      for (int s = 1; s < LAT; s++) begin
        vld_reg[s] <= vld_reg[s-1];
        tag_reg[s] <= tag_reg[s-1];
      end
    end
  end

  assign inflight_next = inflight_reg + 4'(issue) - 4'(vld_reg[LAT-1]);

  // Priority pointer, in-flight counter and FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_reg     <= TW'(NREQ - 1);
      inflight_reg <= 4'd0;
      state_reg    <= ST_RUN;
    end else begin
      if (issue) last_reg <= pick_idx;
      inflight_reg <= inflight_next;
      state_reg    <= state_next;
    end
  end

  // Pause/drain transitions; DRAIN completes once the count reaches zero at this edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:    if (pause) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!pause)                  state_next = ST_RUN;
        else if (inflight_next == 0) state_next = ST_PAUSED;
      end
      ST_PAUSED: if (!pause) state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  assign rsp_sum  = add_sum;
  assign inflight = inflight_reg;
  assign idle     = (state_reg == ST_PAUSED) && (inflight_reg == 4'd0);

endmodule

// File: doc/cla_issue_arbiter.md
# cla_issue_arbiter

Round-robin issue controller that shares one pipelined 16-bit carry-look-ahead adder (5-cycle latency, no valid or tag signals of its own) among NREQ requesters. It grants at most one add per cycle, drives the adder operands, tracks each issued operation through a tag shift register matched to the adder latency, and steers the 17-bit result back to the requester that issued it. A pause/drain state machine lets system control quiesce the adder.

## Interface
- NREQ, 4: number of requesters, 2..8.
- LAT, 5: adder latency in clock edges from operands driven to `sum_final` valid, 1..8.
- TW, $clog2(NREQ): tag width.

- clk  in  1  rising-edge clock, shared with the adder.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req  in  NREQ  per-requester request; held with operands until granted.
- req_a  in  16*NREQ  operand A, requester i at bits [16i+15:16i].
- req_b  in  16*NREQ  operand B, same packing.
- gnt  out  NREQ  one-hot grant, combinational, same cycle as issue.
- add_a  out  16  adder operand A.
- add_b  out  16  adder operand B.
- add_sum  in  17  adder `sum_final` {carry, sum[15:0]}.
- rsp_valid  out  NREQ  one-hot, single-cycle result strobe.
- rsp_sum  out  17  result; valid only while any rsp_valid bit is high.
- pause  in  1  stop issuing and drain.
- idle  out  1  paused and adder pipeline empty.
- inflight  out  4  count of issued, not-yet-returned operations.

## Operation
- Arbitration: round-robin. Priority starts at `last+1` mod NREQ. `last` updates to the granted index on each grant. Reset value of `last` is NREQ-1, so requester 0 has first priority.
- Issue: in state RUN with any req bit high, exactly one gnt bit goes high. `add_a`/`add_b` come from the granted requester's slice. The requester drops or changes req/operands after the edge on which gnt is high.
- Tag pipe: LAT stages of {valid, tag[TW-1:0]}. Stage 0 loads {issue, granted index} each edge, and each stage shifts every edge. The last stage drives `rsp_valid[tag]` = valid, and `rsp_sum` = add_sum.
- inflight: +1 on issue, -1 on last-stage valid. Both in the same cycle leaves it unchanged. It never exceeds LAT.
- FSM states:
  - RUN: granting. On pause=1, go to DRAIN, and no grant is given in that cycle.
  - DRAIN: no grants. Go to PAUSED when inflight==0 at the edge. On pause=0, return to RUN.
  - PAUSED: no grants, idle=1. On pause=0, go to RUN; grants resume the next cycle.
  - If inflight is already 0 when pause rises, the FSM passes RUN→DRAIN→PAUSED on consecutive edges.
- Reset values: state RUN; tag pipe all invalid; inflight 0; gnt 0; rsp_valid 0; idle 0; add_a/add_b 0. Mid-operation reset discards every in-flight op with no rsp_valid. The adder's own synchronous active-high reset is the integrator's concern. Stale adder contents are ignored because the tag pipe is cleared.

## Timing
- Issue in cycle T. `rsp_valid` is high for exactly cycle T+LAT, with `rsp_sum` = req_a+req_b (17-bit, carry in bit 16).
- Back-to-back issue at one per cycle yields one response per cycle, in order, with no bubbles.
- gnt and add_a/add_b are combinational from req, `last`, and state. Every other output is a function of registered state plus `add_sum`.
- pause sampled high in cycle T: no gnt in cycle T onward. idle rises no later than cycle T+LAT+1.

## Configuration
- CLA_ARB_ZERO_IDLE_EN defined: on cycles with no grant, add_a and add_b are driven 16'h0000. This cuts adder toggling, and the idle-slot result is 0.
- Not defined: add_a and add_b are registered and hold the last issued operands on non-grant cycles. A grant cycle still drives the granted operands combinationally.
- Either way, non-grant slots never produce rsp_valid.

## Test plan
- Single op: NREQ=4, req[2]=1 with a=16'hFFFF, b=16'h0001 at T → gnt=4'b0100 at T; rsp_valid=4'b0100 and rsp_sum=17'h10000 at T+5 only.
- Fairness: all four req held continuously for 8 cycles → grants 0,1,2,3,0,1,2,3. Responses arrive in the same order, 5 cycles later, one per cycle.
- Pause/drain: 3 ops issued, pause=1 on the next cycle → no further gnt; inflight counts 3→0; idle=1 by the cycle after the last rsp_valid. pause=0 → grant on the following cycle.
- Reset mid-flight: reset low for 1 cycle with inflight=4 → all outputs at reset values; no rsp_valid for the next 10 cycles without new req; requester 0 wins the next contention.
- Simultaneous issue and return: steady 1/cycle stream → inflight holds at 5. Random operands match the a+b reference model for 1000 ops.
- Macro: with CLA_ARB_ZERO_IDLE_EN, add_a=add_b=0 on idle cycles; without it, they equal the last granted operands.
